// File: rtl/dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dcm_reset_sequencer
// Brief   : Pulses DCM reset, waits for and qualifies lock, then releases the
//           system reset; re-arms the DCM on lock loss or a stopped clock.
// Revision: 1.0 - initial release
// ============================================================================
module dcm_reset_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dcm_locked_i,
    input  logic [7:0] dcm_status_i,
    output logic       dcm_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic [3:0] retry_cnt_o,
    output logic       fail_o
);

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_RETRY     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMER_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_TIMER_ONE   = CNT_W'(1);
    localparam logic [3:0]       C_RETRY_SAT   = 4'hF;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             dcm_rst_q, dcm_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic             fail_q, fail_d;

    logic             locked_meta_q, locked_s_q;
    logic             stop_meta_q, stop_s_q;
    logic             w_stop_raw;
    logic             w_lost;
    logic             w_status_unused;

    // Only the two "clock stopped" flags matter to the sequencer.
    assign w_stop_raw      = dcm_status_i[1] | dcm_status_i[2];
    assign w_status_unused = ^{dcm_status_i[7:3], dcm_status_i[0]};
    assign w_lost          = !locked_s_q || stop_s_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            stop_meta_q   <= 1'b0;
            stop_s_q      <= 1'b0;
        end else begin
            locked_meta_q <= dcm_locked_i;
            locked_s_q    <= locked_meta_q;
            stop_meta_q   <= w_stop_raw;
            stop_s_q      <= stop_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        fail_d      = fail_q;

        case (state_q)
            ST_RST_HOLD: begin
                if (timer_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle takes priority over a retry.
                if (locked_s_q)                state_d = ST_STABLE;
                else if (timer_q == C_LOCK_LAST) state_d = ST_RETRY;
            end
            ST_STABLE: begin
                if (w_lost)                        state_d = ST_RETRY;
                else if (timer_q == C_STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_lost) state_d = ST_RETRY;
            end
            ST_RETRY: begin
                state_d = ST_RST_HOLD;
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase

        if (state_d != state_q)        timer_d = '0;
        else if (timer_q != C_TIMER_MAX) timer_d = timer_q + C_TIMER_ONE;

        // RETRY lasts exactly one cycle, so this fires once per re-arm.
        if (state_d == ST_RETRY) begin
            if (retry_cnt_q != C_RETRY_SAT) retry_cnt_d = retry_cnt_q + 4'd1;
            if (int'(retry_cnt_d) >= MAX_RETRIES) fail_d = 1'b1;
        end

        dcm_rst_d = (state_d == ST_RST_HOLD);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RST_HOLD;
            timer_q     <= '0;
            dcm_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            retry_cnt_q <= 4'd0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dcm_rst_q   <= dcm_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            retry_cnt_q <= retry_cnt_d;
            fail_q      <= fail_d;
        end
    end

    assign dcm_rst_o   = dcm_rst_q;
    assign sys_rst_o   = sys_rst_q;
    assign ready_o     = ready_q;
    assign retry_cnt_o = retry_cnt_q;
    assign fail_o      = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcm_reset_sequencer
// Brief   : Directed plus randomized bench for dcm_reset_sequencer against a
//           phase/elapsed-time reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dcm_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRIES   = 3;
    localparam int CNT_W         = 20;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_RETRY  = 4;

    logic       clk_i        = 1'b0;
    logic       rst_i        = 1'b1;
    logic       dcm_locked_i = 1'b0;
    logic [7:0] dcm_status_i = 8'h00;
    logic       dcm_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic [3:0] retry_cnt_o;
    logic       fail_o;

    dcm_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dcm_locked_i (dcm_locked_i),
        .dcm_status_i (dcm_status_i),
        .dcm_rst_o    (dcm_rst_o),
        .sys_rst_o    (sys_rst_o),
        .ready_o      (ready_o),
        .retry_cnt_o  (retry_cnt_o),
        .fail_o       (fail_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current phase, edge index of phase entry, and 2-deep
    // delay lines standing in for the synchronisers.
    int m_phase;
    int m_entry;
    int m_edges;
    int m_retries;
    bit m_fail;
    bit lk_pipe[$];
    bit st_pipe[$];

    task automatic model_reset();
        m_phase   = P_HOLD;
        m_entry   = 0;
        m_edges   = 0;
        m_retries = 0;
        m_fail    = 1'b0;
        lk_pipe   = '{1'b0, 1'b0};
        st_pipe   = '{1'b0, 1'b0};
    endtask

    task automatic model_edge();
        bit lk, stp;
        int elapsed, nxt;
        lk  = lk_pipe.pop_front();
        stp = st_pipe.pop_front();
        lk_pipe.push_back(dcm_locked_i);
        st_pipe.push_back(dcm_status_i[1] | dcm_status_i[2]);
        elapsed = m_edges - m_entry;
        nxt     = m_phase;
        case (m_phase)
            P_HOLD:   if (elapsed == RST_CYCLES - 1) nxt = P_WAIT;
            P_WAIT:   if (lk) nxt = P_STABLE;
                      else if (elapsed == LOCK_TIMEOUT - 1) nxt = P_RETRY;
            P_STABLE: if (!lk || stp) nxt = P_RETRY;
                      else if (elapsed == STABLE_CYCLES - 1) nxt = P_RUN;
            P_RUN:    if (!lk || stp) nxt = P_RETRY;
            default:  nxt = P_HOLD;
        endcase
        m_edges++;
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_entry = m_edges;
            if (nxt == P_RETRY) begin
                m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                if (m_retries >= MAX_RETRIES) m_fail = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " dcm_rst_o"},   dcm_rst_o,   (m_phase == P_HOLD));
        chk({tag, " sys_rst_o"},   sys_rst_o,   (m_phase != P_RUN));
        chk({tag, " ready_o"},     ready_o,     (m_phase == P_RUN));
        chk({tag, " retry_cnt_o"}, retry_cnt_o, m_retries);
        chk({tag, " fail_o"},      fail_o,      m_fail);
    endtask

    task automatic tick_r(input logic lk, input logic [7:0] st, input logic r);
        @(negedge clk_i);
        rst_i        = r;
        dcm_locked_i = lk;
        dcm_status_i = st;
        @(posedge clk_i);
        if (!rst_i) model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic tick(input logic lk, input logic [7:0] st);
        tick_r(lk, st, 1'b0);
    endtask

    // Reset lands between edges; outputs must be at reset values before any edge.
    task automatic async_reset(input string tag);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        model_reset();
        chk({tag, " dcm_rst_o"},   dcm_rst_o,   1);
        chk({tag, " sys_rst_o"},   sys_rst_o,   1);
        chk({tag, " ready_o"},     ready_o,     0);
        chk({tag, " retry_cnt_o"}, retry_cnt_o, 0);
        chk({tag, " fail_o"},      fail_o,      0);
        tick_r(1'b0, 8'h00, 1'b1);
        tick_r(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t_rst_low, t_run, t_evt, n_pulse, nchg, t1, t2;
        bit   saw_run, dead;
        logic f2, f3;
        logic [3:0] prev;
        logic lk;
        logic [7:0] st;

        // Power-on reset
        model_reset();
        repeat (3) tick_r(1'b0, 8'h00, 1'b1);
        chk("por dcm_rst_o", dcm_rst_o, 1);
        chk("por sys_rst_o", sys_rst_o, 1);
        chk("por ready_o",   ready_o,   0);

        // Release; locked rises on the 10th edge. dcm_rst drops after 4 edges,
        // sys_rst drops 18 edges after the edge that first samples locked.
        t_rst_low = 0;
        t_run     = 0;
        for (int t = 1; t <= 40; t++) begin
            tick(t >= 10, 8'h00);
            if (t_rst_low == 0 && !dcm_rst_o) t_rst_low = t;
            if (t_run == 0 && !sys_rst_o) t_run = t;
        end
        chk("s1 dcm_rst width", t_rst_low, RST_CYCLES);
        chk("s1 run edge",      t_run,     10 + 18);
        chk("s1 retry_cnt",     retry_cnt_o, 0);

        // RUN: one-cycle lock drop
        tick(1'b0, 8'h00);
        t_evt   = 0;
        n_pulse = 0;
        for (int t = 1; t <= 40; t++) begin
            tick(1'b1, 8'h00);
            if (t_evt == 0 && sys_rst_o && !ready_o) t_evt = t;
            if (dcm_rst_o) n_pulse++;
        end
        chk("s3 exit latency", t_evt, 2);
        chk("s3 dcm_rst pulse", n_pulse, RST_CYCLES);
        chk("s3 retry_cnt", retry_cnt_o, 1);
        chk("s3 relock ready", ready_o, 1);

        // RUN: CLKFX stopped
        tick(1'b1, 8'h04);
        t_evt = 0;
        for (int t = 1; t <= 40; t++) begin
            tick(1'b1, 8'h00);
            if (t_evt == 0 && sys_rst_o) t_evt = t;
        end
        chk("s5 stop latency", t_evt, 2);
        chk("s5 retry_cnt", retry_cnt_o, 2);
        chk("s5 fail below max", fail_o, 0);
        chk("s5 relock ready", ready_o, 1);

        // Lock lost with stop flags raised: third retry sets fail, flags ignored in WAIT_LOCK
        for (int t = 1; t <= 30; t++) tick(1'b0, 8'h06);
        chk("s5b retry_cnt", retry_cnt_o, 3);
        chk("s5b fail at max", fail_o, 1);
        for (int t = 1; t <= 40; t++) tick(1'b1, 8'h00);
        chk("s5b ready", ready_o, 1);
        chk("s5b retry_cnt kept", retry_cnt_o, 3);

        // Async reset mid-RUN, then glitch lock on the last STABLE cycle
        async_reset("rst_run");
        saw_run = 1'b0;
        for (int t = 1; t <= 45; t++) begin
            tick((t >= 10) && (t != 26), 8'h00);
            if (!sys_rst_o) saw_run = 1'b1;
        end
        chk("s4 no run", saw_run, 0);
        chk("s4 retry_cnt", retry_cnt_o, 1);

        // Async reset mid-STABLE
        async_reset("rst_stable_pre");
        for (int t = 1; t <= 12; t++) tick(1'b1, 8'h00);
        async_reset("rst_stable");

        // No lock ever: retry cadence, fail threshold, saturation
        nchg = 0; t1 = 0; t2 = 0; f2 = 1'bx; f3 = 1'bx; prev = 4'd0;
        for (int t = 1; t <= 1200; t++) begin
            tick(1'b0, 8'h00);
            if (retry_cnt_o != prev) begin
                nchg++;
                if (nchg == 1) t1 = t;
                if (nchg == 2) t2 = t;
                if (retry_cnt_o == 4'd2) f2 = fail_o;
                if (retry_cnt_o == 4'd3) f3 = fail_o;
                prev = retry_cnt_o;
            end
        end
        chk("s2 first retry edge", t1, RST_CYCLES + LOCK_TIMEOUT);
        chk("s2 retry period", t2 - t1, RST_CYCLES + LOCK_TIMEOUT + 1);
        chk("s2 fail at 2", f2, 0);
        chk("s2 fail at 3", f3, 1);
        chk("s2 saturated", retry_cnt_o, 15);
        chk("s2 fail sticky", fail_o, 1);

        // Randomized traffic
        async_reset("rst_rand");
        dead = 1'b0;
        for (int t = 1; t <= 3000; t++) begin
            if ($urandom_range(0, 299) == 0) dead = ~dead;
            lk = !dead && ($urandom_range(0, 99) < 97);
            st = 8'($urandom) & 8'hF9;
            if ($urandom_range(0, 149) == 0) st = st | 8'($urandom_range(2, 7) << 1) & 8'h06 | 8'h02;
            tick(lk, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
